imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the decode-side immediate generator: packs a 32-bit signed/unsigned immediate into the immediate bit positions of an RV32I instruction template.
- Supported formats: I, S, SB, UJ, U.
- Used by the debug/self-test instruction injector to build branch, jump, load, store and LUI words at run time.
- Two-stage valid/ready pipeline with range/alignment checking and a saturating error counter.

Parameters:
- CNT_W, 16: width of the saturating error counter `err_count`.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  encoder can accept a request this cycle.
- `in_fmt`  input  3  0=I, 1=S, 2=SB, 3=UJ, 4=U; 5–7 are illegal.
- `in_base`  input  32  instruction template; supplies opcode/rd/rs1/rs2/funct bits.
- `in_imm`  input  32  immediate as a byte offset / value, two's complement.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_instr`  output  32  encoded instruction.
- `out_err`  output  1  immediate not representable, or illegal format.
- `err_count`  output  CNT_W  number of accepted results with `out_err`=1; saturates.

Behaviour:
- **Reset** (asynchronous, `rst_n`=0): both stage valids = 0, `out_valid`=0, `out_instr`=0, `out_err`=0, `err_count`=0. Any in-flight request is discarded.
- **Handshake:**
  - Transfer on a side occurs when valid && ready in the same cycle.
  - `out_instr`/`out_err` stay stable while `out_valid`=1 and `out_ready`=0.
- **Pipeline:**
  - S1 registers `fmt`, `base`, `imm` and the precomputed range error. S2 registers the packed word and error.
  - Latency: accept at cycle N → `out_valid`=1 at cycle N+2 when there is no stall. Throughput is 1 per cycle.
  - S2 loads when S2 is empty or being drained this cycle (`out_ready`=1).
  - S1 advances under the same condition.
  - `in_ready` = !S1_valid || S1 advancing. It must not combinationally depend on `in_valid`.
- **Packing:** template immediate positions are overwritten; all other bits come from `in_base`.
  - I: [31:20]=imm[11:0]. Legal range −2048..2047.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Range −2048..2047.
  - SB: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Range −4096..4094; imm[0] must be 0.
  - UJ: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. Range −1048576..1048574; imm[0] must be 0.
  - U: [31:12]=imm[31:12]; imm[11:0] must be 0.
- **Range check:** a value is legal iff `in_imm` equals the sign-extension of its low bits of the format's width. I/S use 12 bits, SB 13, UJ 21. U has no range limit.
- **On error:**
  - Range/alignment error: `out_err`=1 and `out_instr` = `in_base` with that format's immediate positions cleared to 0.
  - Illegal `fmt` (5–7): `out_err`=1 and `out_instr` = `in_base` unchanged.
- **Round-trip invariant:** whenever `out_err`=0, decoding `out_instr` with the matching format returns exactly `in_imm`.
- **`err_count`:**
  - Increments by 1 on each output transfer with `out_err`=1, never on stall cycles.
  - Saturates at 2^CNT_W−1; no wrap-around.
- **Simultaneous events:** drain from S2, advance S1→S2 and accept into S1 may all occur in the same cycle with no bubble.
- **Reset mid-stall:** all valids clear immediately; no result is emitted for the discarded requests after release.

Test Plan:
- I: `fmt`=0, `base`=0x00000093, `imm`=0xFFFFFFFF (−1) → `out_instr`=0xFFF00093, `out_err`=0, two cycles after accept.
- S/SB: `fmt`=1, `base`=0x00002023, `imm`=2044 → 0x7E002E23. Then `fmt`=2, `base`=0x00000063, `imm`=−4 → 0xFE000EE3.
- UJ/U: `fmt`=3, `base`=0x0000006F, `imm`=8 → 0x0080006F. Then `fmt`=4, `base`=0x000000B7, `imm`=0x12345000 → 0x123450B7.
- Errors:
  - SB `imm`=4096 → `out_err`=1, `out_instr`=0x00000063.
  - U `imm`=0x12345678 → `out_err`=1.
  - `fmt`=6 → `out_instr`=`in_base`, `out_err`=1.
  - After these three transfers, `err_count`=3.
- Backpressure: stream 5 back-to-back requests with `out_ready` held 0 for 4 cycles.
  - `in_ready` drops after 2 accepts.
  - Outputs are stable while stalled.
  - All 5 results emerge in order with no loss or duplication.
- Reset/saturation:
  - Assert `rst_n`=0 with both stages full → all outputs 0 at once, and nothing is emitted after release.
  - With CNT_W=2, send 5 errored results → `err_count` holds at 3.

Source files
------------

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Packs a 32-bit two's-complement immediate into the immediate
//                bit positions of an RV32I instruction template (I, S, SB, UJ
//                and U formats). Two-stage valid/ready pipeline with a
//                range/alignment check and a saturating error counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   request valid
//    in_ready   out  encoder can accept a request this cycle
//    in_fmt     in   0=I 1=S 2=SB 3=UJ 4=U, 5..7 illegal
//    in_base    in   instruction template (opcode/rd/rs1/rs2/funct bits)
//    in_imm     in   immediate, two's complement
//    out_valid  out  result valid
//    out_ready  in   downstream accepts the result
//    out_instr  out  encoded instruction
//    out_err    out  immediate not representable or illegal format
//    err_count  out  saturating count of transferred results with out_err=1
// ============================================================================
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] c_FMT_I  = 3'd0;
    localparam logic [2:0] c_FMT_S  = 3'd1;
    localparam logic [2:0] c_FMT_SB = 3'd2;
    localparam logic [2:0] c_FMT_UJ = 3'd3;
    localparam logic [2:0] c_FMT_U  = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Range / alignment / format check, evaluated on the request itself so
    // that S1 only has to carry a single error bit forward.
    // ------------------------------------------------------------------
    function automatic logic f_imm_err(input logic [2:0] fmt, input logic [31:0] imm);
        logic err;
        err = 1'b1;
        case (fmt)
            c_FMT_I, c_FMT_S: err = (imm != {{20{imm[11]}}, imm[11:0]});
            c_FMT_SB:         err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            c_FMT_UJ:         err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            c_FMT_U:          err = (imm[11:0] != 12'd0);
            default:          err = 1'b1;
        endcase
        return err;
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic [2:0]  r_s1_fmt;
    logic [31:0] r_s1_base;
    logic [31:0] r_s1_imm;
    logic        r_s1_err;

    logic        r_s2_valid;
    logic [31:0] r_s2_instr;
    logic        r_s2_err;

    logic [CNT_W-1:0] r_err_count;

    // S2 takes new data when it is empty or is handing its word off now;
    // S1 moves forward on exactly the same condition.
    logic w_s2_load;
    logic w_s1_accept;
    logic w_out_xfer;

    assign w_s2_load   = !r_s2_valid || out_ready;
    assign in_ready    = !r_s1_valid || w_s2_load;
    assign w_s1_accept = in_valid && in_ready;
    assign w_out_xfer  = r_s2_valid && out_ready;

    // ------------------------------------------------------------------
    // Packing of the S1 contents. w_mask marks the immediate bit positions
    // of the format; w_field holds the immediate scattered into them.
    // Illegal formats use an empty mask so the template passes through.
    // ------------------------------------------------------------------
    logic [31:0] w_mask;
    logic [31:0] w_field;
    logic [31:0] w_packed;

    always_comb begin
        w_mask  = 32'h0000_0000;
        w_field = 32'h0000_0000;
        case (r_s1_fmt)
            c_FMT_I: begin
                w_mask  = 32'hFFF0_0000;
                w_field = {r_s1_imm[11:0], 20'd0};
            end
            c_FMT_S: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {r_s1_imm[11:5], 13'd0, r_s1_imm[4:0], 7'd0};
            end
            c_FMT_SB: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {r_s1_imm[12], r_s1_imm[10:5], 13'd0,
                           r_s1_imm[4:1], r_s1_imm[11], 7'd0};
            end
            c_FMT_UJ: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                           r_s1_imm[19:12], 12'd0};
            end
            c_FMT_U: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {r_s1_imm[31:12], 12'd0};
            end
            default: begin
                w_mask  = 32'h0000_0000;
                w_field = 32'h0000_0000;
            end
        endcase
        // On a range error the immediate positions are left cleared.
        w_packed = (r_s1_base & ~w_mask) | (r_s1_err ? 32'h0000_0000 : w_field);
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_fmt   <= 3'd0;
            r_s1_base  <= 32'd0;
            r_s1_imm   <= 32'd0;
            r_s1_err   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt  <= in_fmt;
                r_s1_base <= in_base;
                r_s1_imm  <= in_imm;
                r_s1_err  <= f_imm_err(in_fmt, in_imm);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 (output register); holds its word while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'd0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_packed;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counter: counts errored results as they leave, saturating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_out_xfer && r_s2_err && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign err_count = r_err_count;

    // w_s1_accept is kept for readability of the handshake; it has no
    // further consumer because S1 loads directly on in_ready.
    logic w_unused;
    assign w_unused = w_s1_accept;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Directed self-checking bench for imm_encoder. A second
//                instance with a 2-bit counter shares the stimulus to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_instr;
    logic        sat_out_err;
    logic [1:0]  sat_err_count;

    int n_checks;
    int n_errors;

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    imm_encoder #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_fmt    (in_fmt),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_instr (sat_out_instr),
        .out_err   (sat_out_err),
        .err_count (sat_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request with out_ready=1; checks latency and result.
    task automatic single(input string tag, input logic [2:0] fmt, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] exp_instr,
                          input logic exp_err);
        in_valid = 1'b1;
        in_fmt   = fmt;
        in_base  = base;
        in_imm   = imm;
        #1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        tick();
    endtask

    initial begin
        int idx;
        int got;
        int seen;
        logic [31:0] held;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 3'd0;
        in_base   = 32'd0;
        in_imm    = 32'd0;
        out_ready = 1'b1;
        held      = 32'd0;

        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err",   {31'd0, out_err}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Legal encodings
        single("i_m1",   3'd0, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        single("s_2044", 3'd1, 32'h0000_2023, 32'd2044,      32'h7E00_2E23, 1'b0);
        single("sb_m4",  3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        single("uj_8",   3'd3, 32'h0000_006F, 32'd8,         32'h0080_006F, 1'b0);
        single("u_lui",  3'd4, 32'h0000_00B7, 32'h1234_5000, 32'h1234_50B7, 1'b0);
        single("sb_max", 3'd2, 32'h0000_0063, 32'd4094,      32'h7E00_0FE3, 1'b0);
        single("uj_min", 3'd3, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
        single("i_2047", 3'd0, 32'h0000_0093, 32'd2047,      32'h7FF0_0093, 1'b0);
        check("cnt_none", {16'd0, err_count}, 32'd0);

        // Error cases
        single("sb_4096", 3'd2, 32'h0000_0063, 32'd4096,      32'h0000_0063, 1'b1);
        single("u_low",   3'd4, 32'h0000_00B7, 32'h1234_5678, 32'h0000_00B7, 1'b1);
        single("fmt6",    3'd6, 32'hABCD_E0B3, 32'd5,         32'hABCD_E0B3, 1'b1);
        check("cnt_3", {16'd0, err_count}, 32'd3);
        single("i_2048",  3'd0, 32'hFFFF_FF93, 32'd2048,      32'h000F_FF93, 1'b1);
        single("sb_odd",  3'd2, 32'hFFFF_FFE3, 32'd6 + 32'd1, 32'h01FF_F063, 1'b1);
        check("cnt_5", {16'd0, err_count}, 32'd5);
        check("sat_cnt_hold", {30'd0, sat_err_count}, 32'd3);

        // Backpressure: 5 back-to-back I requests, out_ready low for 4 cycles.
        idx  = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            out_ready = (c >= 4);
            if (idx < 5) begin
                in_valid = 1'b1;
                in_fmt   = 3'd0;
                in_base  = 32'h0000_0013;
                in_imm   = 32'(idx + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                check("bp_accepts", 32'(idx), 32'd2);
                held = out_instr;
            end
            if (c == 3) begin
                check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
                check("bp_stall_stable", out_instr, held);
            end
            if (out_valid && out_ready) begin
                check("bp_order", out_instr, {12'(got + 1), 20'h00013});
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(got), 32'd5);
        tick();
        tick();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full of errored requests.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd7;
        in_base   = 32'h1111_2222;
        in_imm    = 32'd0;
        tick();
        tick();
        #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_err",   {31'd0, out_err}, 32'd0);
        check("mid_rst_cnt",   {16'd0, err_count}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("post_rst_silent", 32'(seen), 32'd0);

        // Saturation: five errored results.
        for (int k = 0; k < 5; k++) begin
            single("sat_err", 3'd5, 32'h0000_0033, 32'd0, 32'h0000_0033, 1'b1);
        end
        check("sat_main_cnt", {16'd0, err_count}, 32'd5);
        check("sat_cnt2", {30'd0, sat_err_count}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
